// File: rtl/io_bus_master.sv
// CPU-side initiator for the memory-mapped IO bus: one load/store becomes a word-wide
// bus transaction; sub-word stores use read-modify-write, loads are extended.
module io_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_uns,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic        busy,
  output logic [31:0] addr,
  output logic [31:0] dout,
  output logic        we,
  output logic        rreq,
  input  logic [31:0] di,
  input  logic        rdy,
  output logic [2:0]  dbg_state
);

  // Bus handshake: a strobe (rreq or we) is raised with addr/dout already stable and is
  // held until rdy is sampled high on a rising edge; that edge ends the phase and the
  // strobe is low the following cycle. rdy is ignored while no strobe is high.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        gap, gap_n;
  logic [31:0] addr_n, dout_n, rdata_n;
  logic        we_n, rreq_n, done_n, err_n, accept;
  logic [1:0]  r_size, r_lane;
  logic        r_uns;
  logic [15:0] r_wdata;
  logic [31:0] merged, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        misaligned, cnt_last;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign cnt_last  = (cnt == CNT_LAST);
  assign misaligned = ((mem_size == 2'b01) && mem_addr[0]) ||
                      (mem_size[1] && (mem_addr[1:0] != 2'b00));

  // Lane extraction and store merge, both little-endian (lane 0 = bits 7:0).
  always_comb begin
    case (r_lane)
      2'd0:    lane_b = di[7:0];
      2'd1:    lane_b = di[15:8];
      2'd2:    lane_b = di[23:16];
      default: lane_b = di[31:24];
    endcase
    lane_h = r_lane[1] ? di[31:16] : di[15:0];
    case (r_size)
      2'b00:   load_ext = {{24{lane_b[7] & ~r_uns}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~r_uns}}, lane_h};
      default: load_ext = di;
    endcase
    merged = di;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd0:    merged[7:0]   = r_wdata[7:0];
        2'd1:    merged[15:8]  = r_wdata[7:0];
        2'd2:    merged[23:16] = r_wdata[7:0];
        default: merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_lane[1]) begin
      merged[31:16] = r_wdata;
    end else begin
      merged[15:0] = r_wdata;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gap_n   = 1'b0;
    addr_n  = addr;
    dout_n  = dout;
    rdata_n = mem_rdata;
    we_n    = 1'b0;
    rreq_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req) begin
          accept = 1'b1;
          cnt_n  = 16'd0;
          addr_n = {mem_addr[31:2], 2'b00};
          if (misaligned) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else if (!mem_we) begin
            state_n = S_RD;
            rreq_n  = 1'b1;
          end else if (mem_size[1]) begin
            state_n = S_WR;
            we_n    = 1'b1;
            dout_n  = mem_wdata;
          end else begin
            state_n = S_RMW_RD;
            rreq_n  = 1'b1;
          end
        end
      end
      S_RD, S_RMW_RD: begin
        if (rdy) begin
          cnt_n = 16'd0;
          if (state == S_RD) begin
            rdata_n = load_ext;
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            dout_n  = merged;
            state_n = S_RMW_WR;
            gap_n   = 1'b1;
          end
        end else if (cnt_last) begin
          cnt_n   = 16'd0;
          state_n = S_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          rreq_n = 1'b1;
          cnt_n  = cnt + 16'd1;
        end
      end
      S_WR, S_RMW_WR: begin
        // First RMW_WR cycle is the idle turnaround between the read and write phases.
        if (gap) begin
          we_n = 1'b1;
        end else if (rdy) begin
          cnt_n   = 16'd0;
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if (cnt_last) begin
          cnt_n   = 16'd0;
          state_n = S_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          we_n  = 1'b1;
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      gap       <= 1'b0;
      addr      <= 32'd0;
      dout      <= 32'd0;
      mem_rdata <= 32'd0;
      we        <= 1'b0;
      rreq      <= 1'b0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_uns     <= 1'b0;
      r_wdata   <= 16'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap       <= gap_n;
      addr      <= addr_n;
      dout      <= dout_n;
      mem_rdata <= rdata_n;
      we        <= we_n;
      rreq      <= rreq_n;
      mem_done  <= done_n;
      mem_err   <= err_n;
      if (accept) begin
        r_size  <= mem_size;
        r_lane  <= mem_addr[1:0];
        r_uns   <= mem_uns;
        r_wdata <= mem_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: memory-backed responder with programmable wait states,
// reference model of loads/stores, and a scoreboard checked on every completion pulse.
module tb_io_bus_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_uns = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata, addr, dout;
  logic        mem_done, mem_err, busy, we, rreq;
  logic [31:0] di = '0;
  logic        rdy = 1'b0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  io_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_uns(mem_uns), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_err(mem_err), .busy(busy), .addr(addr), .dout(dout),
    .we(we), .rreq(rreq), .di(di), .rdy(rdy), .dbg_state(dbg_state)
  );

  int n_tests = 0, n_fail = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] last_load = '0;
  logic [31:0] exp_waddr = '0, exp_dout = '0;
  int unsigned wait_n = 0;
  int st_lat, st_rc, st_wc, st_gap, st_busy;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] lo);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    ref_mem[wa] = v;
    bus_mem[wa] = v;
  endtask

  // Responder: rdy rises after wait_n wait cycles in each strobe phase.
  initial begin : responder
    int cyc;
    logic in_ph;
    cyc = 0;
    in_ph = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rreq || we) begin
        if (!in_ph) begin
          in_ph = 1'b1;
          cyc = 0;
        end
        cyc++;
        if (cyc > int'(wait_n)) begin
          rdy = 1'b1;
          di  = bus_rd(addr);
          if (we) bus_mem[addr] = dout;
        end else begin
          rdy = 1'b0;
          di  = $urandom;
        end
      end else begin
        in_ph = 1'b0;
        rdy   = 1'b0;
        di    = $urandom;
      end
    end
  end

  // Monitor: bus invariants every cycle, scoreboard pop on each completion pulse.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      n_tests++;
      if (we && rreq) begin
        n_fail++;
        $display("FAIL strobe_overlap: got we=1 rreq=1 expected at most one");
      end
      if (rreq || we) begin
        n_tests++;
        if (addr !== exp_waddr) begin
          n_fail++;
          $display("FAIL bus_addr: got %h expected %h", addr, exp_waddr);
        end
      end
      if (we) begin
        n_tests++;
        if (dout !== exp_dout) begin
          n_fail++;
          $display("FAIL bus_dout: got %h expected %h", dout, exp_dout);
        end
      end
      if (mem_done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got mem_done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          if ({mem_err, mem_rdata} !== e) begin
            n_fail++;
            $display("FAIL done_resp: got err=%0b rdata=%h expected err=%0b rdata=%h",
                     mem_err, mem_rdata, e[32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int unsigned wt);
    logic [31:0] wa, old, nw, mask;
    logic [1:0]  lo;
    logic        mis, err;
    int          sh, last_r, first_w;
    bit          done_seen;
    wa  = {a[31:2], 2'b00};
    lo  = a[1:0];
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (lo != 2'b00));
    err = mis || (wt >= TO);
    old = ref_rd(wa);
    if (sz == 2'b00) begin
      sh = 8 * lo;
      mask = 32'hFF << sh;
    end else if (sz == 2'b01) begin
      sh = 16 * lo[1];
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    nw = (old & ~mask) | ((wd << sh) & mask);
    exp_waddr = wa;
    exp_dout  = nw;
    wait_n    = wt;
    if (!err) begin
      if (w) ref_mem[wa] = nw;
      else last_load = ref_load(old, sz, u, lo);
    end
    exp_q.push_back({err, last_load});
    @(negedge clk);
    mem_req = 1'b1; mem_we = w; mem_size = sz; mem_uns = u; mem_addr = a; mem_wdata = wd;
    @(negedge clk);
    mem_req = 1'b0;
    st_lat = 0; st_rc = 0; st_wc = 0; st_busy = 0; last_r = -1; first_w = -1;
    done_seen = 1'b0;
    for (int c = 1; c <= 200 && !done_seen; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) st_busy++;
      if (rreq) begin st_rc++; last_r = c; end
      if (we && first_w < 0) first_w = c;
      if (we) st_wc++;
      if (mem_done) begin done_seen = 1'b1; st_lat = c; end
    end
    if (!done_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no mem_done in 200 cycles expected completion");
    end
    st_gap = (first_w > 0 && last_r > 0) ? first_w - last_r - 1 : -1;
  endtask

  task automatic reset_mid_rmw();
    bit found;
    preload(32'h0000_0400, 32'h1111_2222);
    exp_waddr = 32'h0000_0400;
    exp_dout  = 32'h1111_AB22;
    wait_n    = 3;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_uns = 1'b0;
    mem_addr = 32'h0000_0401; mem_wdata = 32'h0000_00AB;
    @(negedge clk);
    mem_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (we) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_we_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rreq", 32'(rreq), 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    last_load = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_done", 32'(mem_done), 32'd0);
    end
    check("rst_mem_untouched", bus_rd(32'h0000_0400), 32'h1111_2222);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned r, wt;
    #3 rst_n = 1'b0;
    #2;
    check("reset_addr", addr, 32'd0);
    check("reset_dout", dout, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_ctrl", {27'd0, we, rreq, mem_done, mem_err, busy}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    preload(32'h8000_0004, 32'h8765_4321);
    run_txn(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 0);
    check("wload_lat", st_lat, 2);
    check("wload_rreq_cycles", st_rc, 1);
    check("wload_busy_cycles", st_busy, 2);
    check("wload_rdata", mem_rdata, 32'h8765_4321);

    preload(32'h0000_0100, 32'h80AA_BBCC);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1);
    check("bload_signed", mem_rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0);
    check("bload_unsigned", mem_rdata, 32'h0000_0080);

    preload(32'h0000_0200, 32'hAAAA_BBBB);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234, 4);
    check("hstore_rreq_cycles", st_rc, 5);
    check("hstore_gap", st_gap, 1);
    check("hstore_we_cycles", st_wc, 5);
    check("hstore_mem", bus_rd(32'h0000_0200), 32'h1234_BBBB);

    run_txn(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 0);
    check("misalign_lat", st_lat, 1);
    check("misalign_strobes", st_rc + st_wc, 0);

    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 100);
    check("timeout_rreq_cycles", st_rc, TO);
    check("timeout_lat", st_lat, TO + 1);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, TO - 1);
    check("lastcycle_rreq_cycles", st_rc, TO);

    reset_mid_rmw();
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 0);
    check("post_reset_lat", st_lat, 2);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      wt = (r < 7) ? r % 4 : ((r == 7) ? TO - 1 : ((r == 8) ? TO : 20));
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 22'h0,
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
              $urandom, wt);
    end

    repeat (2) @(negedge clk);
    foreach (ref_mem[k]) check("final_mem", bus_rd(k), ref_mem[k]);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
